// File: rtl/slp_pkg.sv
// Shared definitions for the sliced lane pipe.
// Holds the 4-bit group function and lane slicing helper.
package slp_pkg;

    localparam int GROUP_W = 4;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_PUSH = 2'b10,
        OP_POP  = 2'b01,
        OP_BOTH = 2'b11
    } fifo_op_t;

    function automatic logic [GROUP_W-1:0] lane_func(
        input logic [GROUP_W-1:0] a,
        input logic [GROUP_W-1:0] b
    );
        logic [GROUP_W-1:0] c;
        c[0] = ~a[0];
        c[1] = ~b[0];
        c[2] = ~b[1];
        c[3] = ~((a[1] | a[2]) & (b[1] | b[2]) & (a[3] | b[3]));
        return c;
    endfunction

    function automatic int lane_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/slp_lane_func.sv
// One LANE_W-wide lane: per-group INV/OAI222 function with enable.
// Inputs are masked before use so X on a disabled lane stays contained.
module slp_lane_func
    import slp_pkg::*;
#(
    parameter int LANE_W = 12
) (
    input  logic              i_en,
    input  logic [LANE_W-1:0] i_a,
    input  logic [LANE_W-1:0] i_b,
    output logic [LANE_W-1:0] o_c
);

    localparam int NG = LANE_W / GROUP_W;

    logic [LANE_W-1:0] w_a;
    logic [LANE_W-1:0] w_b;
    logic [LANE_W-1:0] w_c;

    assign w_a = i_a & {LANE_W{i_en}};
    assign w_b = i_b & {LANE_W{i_en}};

    for (genvar g = 0; g < NG; g++) begin : g_grp
        assign w_c[g*GROUP_W +: GROUP_W] =
            lane_func(w_a[g*GROUP_W +: GROUP_W], w_b[g*GROUP_W +: GROUP_W]);
    end

    assign o_c = i_en ? w_c : '0;

endmodule

// File: rtl/sliced_lane_pipe.sv
// Sliced lane array feeding a DEPTH-entry elastic FIFO.
// Valid/ready on both sides; counts output handshakes.
module sliced_lane_pipe
    import slp_pkg::*;
#(
    parameter int NUM_LANES = 3,
    parameter int LANE_W    = 12,
    parameter int DEPTH     = 2,
    parameter int CNT_W     = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_LANES*LANE_W-1:0]   in_a,
    input  logic [NUM_LANES*LANE_W-1:0]   in_b,
    input  logic [NUM_LANES-1:0]          in_lane_en,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_LANES*LANE_W-1:0]   out_c,
    output logic [NUM_LANES-1:0]          out_lane_en,
    output logic [$clog2(DEPTH):0]        occupancy,
    output logic [CNT_W-1:0]              xfer_cnt
);

    localparam int W     = NUM_LANES * LANE_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [W-1:0]         w_res;
    logic                 w_push;
    logic                 w_pop;
    fifo_op_t             w_op;
    logic [OCC_W-1:0]     w_occ_nxt;

    logic [W-1:0]         r_mem_c  [DEPTH];
    logic [NUM_LANES-1:0] r_mem_en [DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [OCC_W-1:0]     r_occ;
    logic [CNT_W-1:0]     r_cnt;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        localparam int LO = lane_lo(k, LANE_W);
        slp_lane_func #(.LANE_W(LANE_W)) u_lane (
            .i_en (in_lane_en[k]),
            .i_a  (in_a[LO +: LANE_W]),
            .i_b  (in_b[LO +: LANE_W]),
            .o_c  (w_res[LO +: LANE_W])
        );
    end

    // No bypass: a full FIFO refuses input even while popping.
    assign in_ready  = rst_n && (r_occ != OCC_W'(DEPTH));
    assign out_valid = (r_occ != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign w_op      = fifo_op_t'({w_push, w_pop});

    always_comb begin
        w_occ_nxt = r_occ;
        unique case (w_op)
            OP_PUSH: w_occ_nxt = r_occ + OCC_W'(1);
            OP_POP:  w_occ_nxt = r_occ - OCC_W'(1);
            default: w_occ_nxt = r_occ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            r_cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_c[i]  <= '0;
                r_mem_en[i] <= '0;
            end
        end else begin
            r_occ <= w_occ_nxt;
            if (w_push) begin
                r_mem_c[r_wr_ptr]  <= w_res;
                r_mem_en[r_wr_ptr] <= in_lane_en;
                r_wr_ptr           <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_cnt    <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign out_c       = out_valid ? r_mem_c[r_rd_ptr]  : '0;
    assign out_lane_en = out_valid ? r_mem_en[r_rd_ptr] : '0;
    assign occupancy   = r_occ;
    assign xfer_cnt    = r_cnt;

endmodule

// File: tb/tb_sliced_lane_pipe.sv
// Directed bench for sliced_lane_pipe with a queue-based reference model.
// A negedge compare process checks every cycle; literals pin the model.
module tb_sliced_lane_pipe;

    localparam int NL = 3;
    localparam int LW = 12;
    localparam int DP = 2;
    localparam int W  = NL * LW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready;
    logic [W-1:0]  in_a, in_b;
    logic [NL-1:0] in_lane_en;
    logic          out_valid, out_ready;
    logic [W-1:0]  out_c;
    logic [NL-1:0] out_lane_en;
    logic [1:0]    occupancy;
    logic [15:0]   xfer_cnt;

    logic          in_valid2, in_ready2, out_valid2;
    logic [W-1:0]  out_c2;
    logic [NL-1:0] out_lane_en2;
    logic [1:0]    occupancy2;
    logic [3:0]    xfer_cnt2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sliced_lane_pipe #(.NUM_LANES(NL), .LANE_W(LW), .DEPTH(DP), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_lane_en(in_lane_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_c(out_c), .out_lane_en(out_lane_en),
        .occupancy(occupancy), .xfer_cnt(xfer_cnt)
    );

    sliced_lane_pipe #(.NUM_LANES(NL), .LANE_W(LW), .DEPTH(DP), .CNT_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .in_a(in_a), .in_b(in_b), .in_lane_en(in_lane_en),
        .out_valid(out_valid2), .out_ready(1'b1),
        .out_c(out_c2), .out_lane_en(out_lane_en2),
        .occupancy(occupancy2), .xfer_cnt(xfer_cnt2)
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] model_lane(input logic [LW-1:0] a,
                                                 input logic [LW-1:0] b);
        logic [LW-1:0] c;
        c = '0;
        for (int g = 0; g < LW / 4; g++) begin
            int i;
            i = 4 * g;
            c[i]   = ~a[i];
            c[i+1] = ~b[i];
            c[i+2] = ~b[i+1];
            c[i+3] = ~((a[i+1] | a[i+2]) & (b[i+1] | b[i+2]) & (a[i+3] | b[i+3]));
        end
        return c;
    endfunction

    function automatic logic [W-1:0] model_out(input logic [W-1:0] a,
                                               input logic [W-1:0] b,
                                               input logic [NL-1:0] en);
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < NL; k++)
            if (en[k]) r[k*LW +: LW] = model_lane(a[k*LW +: LW], b[k*LW +: LW]);
        return r;
    endfunction

    typedef struct {
        logic [W-1:0]  c;
        logic [NL-1:0] en;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] mcnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mcnt = '0;
        end else begin
            int sz;
            sz = mq.size();
            if (out_ready && sz != 0) begin
                void'(mq.pop_front());
                mcnt = mcnt + 16'd1;
            end
            if (in_valid && sz != DP)
                mq.push_back('{model_out(in_a, in_b, in_lane_en), in_lane_en});
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("cmp_out_valid", 64'(out_valid), 64'(mq.size() != 0));
            check("cmp_occupancy", 64'(occupancy), 64'(mq.size()));
            check("cmp_in_ready", 64'(in_ready), 64'(mq.size() != DP));
            check("cmp_xfer_cnt", 64'(xfer_cnt), 64'(mcnt));
            if (mq.size() != 0) begin
                check("cmp_out_c", 64'(out_c), 64'(mq[0].c));
                check("cmp_out_en", 64'(out_lane_en), 64'(mq[0].en));
            end else begin
                check("cmp_out_c_empty", 64'(out_c), 64'd0);
                check("cmp_out_en_empty", 64'(out_lane_en), 64'd0);
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [NL-1:0] en, output int waits);
        in_a = a;
        in_b = b;
        in_lane_en = en;
        in_valid = 1'b1;
        waits = 0;
        for (int t = 0; t < 200; t++) begin
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            waits++;
            @(posedge clk);
            #1;
        end
        check("send_timeout", 64'd1, 64'd0);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #10 rst_n = 1'b1;
        #1;
    endtask

    initial begin
        int w;
        int stalls;
        logic [W-1:0] h0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_valid2 = 1'b0;
        out_ready = 1'b1;
        in_a = '0;
        in_b = '0;
        in_lane_en = '0;

        check("model_pin_fff", 64'(model_lane(12'h000, 12'h000)), 64'hFFF);
        check("model_pin_ffe", 64'(model_lane(12'h00F, 12'h000)), 64'hFFE);

        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_c", 64'(out_c), 64'd0);
        check("rst_occ", 64'(occupancy), 64'd0);
        check("rst_xfer", 64'(xfer_cnt), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        #21 rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        send(36'h0, 36'h0, 3'b001, w);
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_out_c", 64'(out_c), 64'h000000FFF);
        check("t1_en", 64'(out_lane_en), 64'd1);
        @(posedge clk);
        #1;

        send({12'h00F, 12'hFFF, 12'h5A5}, {12'h000, 12'hFFF, 12'h3C3}, 3'b110, w);
        check("t2_out_c", 64'(out_c), 64'hFFE000000);
        check("t2_en", 64'(out_lane_en), 64'(3'b110));
        @(posedge clk);
        #1;

        do_reset();
        out_ready = 1'b0;
        send({12'h111, 12'h222, 12'h333}, {12'h444, 12'h555, 12'h666}, 3'b111, w);
        send({12'h789, 12'hABC, 12'hDEF}, {12'h012, 12'h345, 12'h678}, 3'b011, w);
        in_a = {12'hF0F, 12'h0F0, 12'hAAA};
        in_b = {12'h555, 12'hCCC, 12'h333};
        in_lane_en = 3'b101;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("t3_occ_full", 64'(occupancy), 64'd2);
        check("t3_in_ready", 64'(in_ready), 64'd0);
        h0 = out_c;
        @(posedge clk);
        #1;
        check("t3_head_hold", 64'(out_c), 64'(h0));
        check("t3_head_first", 64'(out_c),
              64'(model_out({12'h111, 12'h222, 12'h333},
                            {12'h444, 12'h555, 12'h666}, 3'b111)));
        out_ready = 1'b1;
        send({12'hF0F, 12'h0F0, 12'hAAA}, {12'h555, 12'hCCC, 12'h333}, 3'b101, w);
        repeat (4) @(posedge clk);
        #1;
        check("t3_xfer", 64'(xfer_cnt), 64'd3);
        check("t3_drained", 64'(occupancy), 64'd0);

        do_reset();
        out_ready = 1'b1;
        stalls = 0;
        for (int i = 0; i < 100; i++) begin
            send(W'(i * 36'h1234567), W'(i * 36'h0FEDCBA + 7), NL'(i % 8), w);
            stalls += w;
        end
        repeat (3) @(posedge clk);
        #1;
        check("t4_stalls", 64'(stalls), 64'd0);
        check("t4_xfer", 64'(xfer_cnt), 64'd100);

        out_ready = 1'b0;
        send(36'h123456789, 36'h987654321, 3'b111, w);
        send(36'h0, 36'h0, 3'b111, w);
        check("t5_occ_full", 64'(occupancy), 64'd2);
        #2 rst_n = 1'b0;
        #1;
        check("t5_valid", 64'(out_valid), 64'd0);
        check("t5_out_c", 64'(out_c), 64'd0);
        check("t5_occ", 64'(occupancy), 64'd0);
        check("t5_xfer", 64'(xfer_cnt), 64'd0);
        check("t5_in_ready", 64'(in_ready), 64'd0);
        #7 rst_n = 1'b1;
        #1;
        check("t5_post_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        send(36'h0, 36'h0, 3'b111, w);
        check("t5_lat_valid", 64'(out_valid), 64'd1);
        check("t5_lat_c", 64'(out_c), 64'hFFFFFFFFF);
        @(posedge clk);
        #1;

        in_a = {12'h3C5, 12'hxxx, 12'h0A0};
        in_b = {12'h000, 12'hxxx, 12'hFFF};
        send(in_a, in_b, 3'b101, w);
        check("t6_no_x", 64'($isunknown(out_c)), 64'd0);
        check("t6_lane1_zero", 64'(out_c[LW +: LW]), 64'd0);
        @(posedge clk);
        #1;
        in_a = '0;
        in_b = '0;

        in_valid2 = 1'b1;
        repeat (17) @(posedge clk);
        #1;
        in_valid2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t6_wrap", 64'(xfer_cnt2), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
